// File: rtl/dbus_arbiter_if.sv
// Shared data-bus bundle between the two requesting masters, the arbiter
// and the bus decoders. The master modport is the environment side (the
// requesters plus the bus device); the slave modport is the arbiter.
interface dbus_arbiter_if;
   logic        m0_req;
   logic        m1_req;
   logic        m0_we;
   logic        m1_we;
   logic [31:0] m0_addr;
   logic [31:0] m1_addr;
   logic [31:0] m0_wdata;
   logic [31:0] m1_wdata;
   logic [1:0]  m0_mode;
   logic [1:0]  m1_mode;
   logic        m0_ack;
   logic        m1_ack;
   logic        m0_err;
   logic        m1_err;
   logic [31:0] m0_rdata;
   logic [31:0] m1_rdata;

   logic        bus_r_en;
   logic        bus_w_en;
   logic [31:0] bus_r_addr;
   logic [31:0] bus_w_addr;
   logic [1:0]  bus_r_mode;
   logic [1:0]  bus_w_mode;
   logic [31:0] bus_w_data;
   logic [31:0] bus_r_data;
   logic [1:0]  bus_state;

   modport master (
      output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
             m0_wdata, m1_wdata, m0_mode, m1_mode,
             bus_r_data, bus_state,
      input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
             bus_r_en, bus_w_en, bus_r_addr, bus_w_addr,
             bus_r_mode, bus_w_mode, bus_w_data
   );

   modport slave (
      input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
             m0_wdata, m1_wdata, m0_mode, m1_mode,
             bus_r_data, bus_state,
      output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
             bus_r_en, bus_w_en, bus_r_addr, bus_w_addr,
             bus_r_mode, bus_w_mode, bus_w_data
   );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter and transaction sequencer for the shared
// data bus. One transaction outstanding at a time, guarded by a timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transaction; pick a requester, latch its request
// ST_ISSUE | one-cycle read or write strobe is on the bus
// ST_WAIT  | waiting for bus_state == done, timeout counting down
// ST_RESP  | one-cycle ack (+rdata/err) to the granted master
module dbus_arbiter #(
   parameter int TIMEOUT = 255
) (
   input logic           clk,
   input logic           rst,
   dbus_arbiter_if.slave dbus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [1:0] BUS_DONE = 2'b10;
   localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        gnt_q, gnt_d;
   logic        we_q, we_d;
   logic [7:0]  cnt_q, cnt_d;

   // The bus channel registers double as the latched address/mode/data of
   // the granted transaction: they only change at grant and hold otherwise.
   logic        r_en_q, r_en_d;
   logic        w_en_q, w_en_d;
   logic [31:0] r_addr_q, r_addr_d;
   logic [31:0] w_addr_q, w_addr_d;
   logic [1:0]  r_mode_q, r_mode_d;
   logic [1:0]  w_mode_q, w_mode_d;
   logic [31:0] w_data_q, w_data_d;

   logic        m0_ack_q, m0_ack_d;
   logic        m1_ack_q, m1_ack_d;
   logic        m0_err_q, m0_err_d;
   logic        m1_err_q, m1_err_d;
   logic [31:0] m0_rdata_q, m0_rdata_d;
   logic [31:0] m1_rdata_q, m1_rdata_d;

   logic        sel;
   logic        sel_valid;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [1:0]  sel_mode;
   logic        resp_fire;
   logic        resp_err;
   logic [31:0] resp_rdata;

   // Request selection: lone requester wins, contention goes to the master
   // that was not granted last.
   always_comb begin
      sel_valid = dbus.m0_req | dbus.m1_req;
      if (dbus.m0_req && dbus.m1_req) begin
         sel = ~last_q;
      end else begin
         sel = dbus.m1_req;
      end
      sel_we    = sel ? dbus.m1_we    : dbus.m0_we;
      sel_addr  = sel ? dbus.m1_addr  : dbus.m0_addr;
      sel_wdata = sel ? dbus.m1_wdata : dbus.m0_wdata;
      sel_mode  = sel ? dbus.m1_mode  : dbus.m0_mode;
   end

   // Next-state and next-output logic; every output is registered, so the
   // strobe/ack values are computed one cycle ahead of the state they belong to.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      we_d       = we_q;
      cnt_d      = cnt_q;
      r_en_d     = 1'b0;
      w_en_d     = 1'b0;
      r_addr_d   = r_addr_q;
      w_addr_d   = w_addr_q;
      r_mode_d   = r_mode_q;
      w_mode_d   = w_mode_q;
      w_data_d   = w_data_q;
      resp_fire  = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'h0;

      case (state_q)
         ST_IDLE: begin
            if (sel_valid) begin
               state_d = ST_ISSUE;
               last_d  = sel;
               gnt_d   = sel;
               we_d    = sel_we;
               if (sel_we) begin
                  w_en_d   = 1'b1;
                  w_addr_d = sel_addr;
                  w_mode_d = sel_mode;
                  w_data_d = sel_wdata;
               end else begin
                  r_en_d   = 1'b1;
                  r_addr_d = sel_addr;
                  r_mode_d = sel_mode;
               end
            end
         end

         ST_ISSUE: begin
            cnt_d   = TMO_LOAD;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            // Done wins over timeout when both land in the same cycle.
            if (dbus.bus_state == BUS_DONE) begin
               state_d    = ST_RESP;
               resp_fire  = 1'b1;
               resp_rdata = we_q ? 32'h0 : dbus.bus_r_data;
            end else if (cnt_q == 8'd0) begin
               state_d   = ST_RESP;
               resp_fire = 1'b1;
               resp_err  = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      m0_ack_d   = resp_fire & ~gnt_q;
      m1_ack_d   = resp_fire &  gnt_q;
      m0_err_d   = resp_err  & ~gnt_q;
      m1_err_d   = resp_err  &  gnt_q;
      m0_rdata_d = gnt_q ? 32'h0 : resp_rdata;
      m1_rdata_d = gnt_q ? resp_rdata : 32'h0;
   end

   // State and output registers; last starts at 1 so master 0 wins the
   // first contention after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         last_q     <= 1'b1;
         gnt_q      <= 1'b0;
         we_q       <= 1'b0;
         cnt_q      <= 8'd0;
         r_en_q     <= 1'b0;
         w_en_q     <= 1'b0;
         r_addr_q   <= 32'h0;
         w_addr_q   <= 32'h0;
         r_mode_q   <= 2'b00;
         w_mode_q   <= 2'b00;
         w_data_q   <= 32'h0;
         m0_ack_q   <= 1'b0;
         m1_ack_q   <= 1'b0;
         m0_err_q   <= 1'b0;
         m1_err_q   <= 1'b0;
         m0_rdata_q <= 32'h0;
         m1_rdata_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         r_en_q     <= r_en_d;
         w_en_q     <= w_en_d;
         r_addr_q   <= r_addr_d;
         w_addr_q   <= w_addr_d;
         r_mode_q   <= r_mode_d;
         w_mode_q   <= w_mode_d;
         w_data_q   <= w_data_d;
         m0_ack_q   <= m0_ack_d;
         m1_ack_q   <= m1_ack_d;
         m0_err_q   <= m0_err_d;
         m1_err_q   <= m1_err_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

   // Drive the interface from the output registers.
   always_comb begin
      dbus.bus_r_en   = r_en_q;
      dbus.bus_w_en   = w_en_q;
      dbus.bus_r_addr = r_addr_q;
      dbus.bus_w_addr = w_addr_q;
      dbus.bus_r_mode = r_mode_q;
      dbus.bus_w_mode = w_mode_q;
      dbus.bus_w_data = w_data_q;
      dbus.m0_ack     = m0_ack_q;
      dbus.m1_ack     = m1_ack_q;
      dbus.m0_err     = m0_err_q;
      dbus.m1_err     = m1_err_q;
      dbus.m0_rdata   = m0_rdata_q;
      dbus.m1_rdata   = m1_rdata_q;
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter with TIMEOUT = 4. Cycle n is the clock
// period after the n-th edge of a scenario; inputs are driven and outputs
// sampled 1 time unit after the rising edge.
module tb_dbus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   dbus_arbiter_if bus_if ();

   dbus_arbiter #(.TIMEOUT(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .dbus (bus_if.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {26'h0, bus_if.m0_ack, bus_if.m1_ack, bus_if.m0_err,
                          bus_if.m1_err, bus_if.bus_r_en, bus_if.bus_w_en}, 32'h0);
      chk({tag, "_mode"}, {28'h0, bus_if.bus_r_mode, bus_if.bus_w_mode}, 32'h0);
      chk({tag, "_raddr"}, bus_if.bus_r_addr, 32'h0);
      chk({tag, "_waddr"}, bus_if.bus_w_addr, 32'h0);
      chk({tag, "_wdata"}, bus_if.bus_w_data, 32'h0);
      chk({tag, "_rdata"}, bus_if.m0_rdata | bus_if.m1_rdata, 32'h0);
   endtask

   initial begin
      bus_if.m0_req = 0; bus_if.m1_req = 0;
      bus_if.m0_we = 0;  bus_if.m1_we = 0;
      bus_if.m0_addr = 0; bus_if.m1_addr = 0;
      bus_if.m0_wdata = 0; bus_if.m1_wdata = 0;
      bus_if.m0_mode = 0; bus_if.m1_mode = 0;
      bus_if.bus_r_data = 0; bus_if.bus_state = 2'b00;

      // Reset state
      tick(); tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();

      // Single read, master 0
      bus_if.m0_req = 1; bus_if.m0_we = 0; bus_if.m0_addr = 32'h1004; bus_if.m0_mode = 2'b10;
      tick();                                            // cycle 1
      chk("rd_r_en_c1", bus_if.bus_r_en, 1);
      chk("rd_w_en_c1", bus_if.bus_w_en, 0);
      chk("rd_addr", bus_if.bus_r_addr, 32'h1004);
      chk("rd_mode", bus_if.bus_r_mode, 2'b10);
      tick();                                            // cycle 2
      chk("rd_r_en_c2", bus_if.bus_r_en, 0);
      bus_if.bus_state = 2'b01;
      tick();                                            // cycle 3
      chk("rd_ack_c3", bus_if.m0_ack, 0);
      bus_if.bus_state = 2'b10; bus_if.bus_r_data = 32'hCAFEF00D;
      tick();                                            // cycle 4
      chk("rd_ack", {bus_if.m1_ack, bus_if.m0_ack}, 2'b01);
      chk("rd_rdata", bus_if.m0_rdata, 32'hCAFEF00D);
      chk("rd_err", bus_if.m0_err, 0);
      chk("rd_m1_rdata", bus_if.m1_rdata, 0);
      bus_if.m0_req = 0; bus_if.bus_state = 2'b00;
      tick();                                            // cycle 5
      chk("rd_ack_c5", bus_if.m0_ack, 0);

      // Write, master 1
      bus_if.m1_req = 1; bus_if.m1_we = 1; bus_if.m1_addr = 32'h10;
      bus_if.m1_wdata = 32'hA5; bus_if.m1_mode = 2'b00;
      tick();                                            // cycle 1
      chk("wr_w_en", bus_if.bus_w_en, 1);
      chk("wr_r_en", bus_if.bus_r_en, 0);
      chk("wr_addr", bus_if.bus_w_addr, 32'h10);
      chk("wr_data", bus_if.bus_w_data, 32'hA5);
      chk("wr_mode", bus_if.bus_w_mode, 2'b00);
      chk("wr_r_addr_hold", bus_if.bus_r_addr, 32'h1004);
      tick();                                            // cycle 2
      chk("wr_w_en_c2", bus_if.bus_w_en, 0);
      bus_if.bus_state = 2'b10; bus_if.bus_r_data = 32'hDEADBEEF;
      tick();                                            // cycle 3
      chk("wr_ack", {bus_if.m1_ack, bus_if.m0_ack}, 2'b10);
      chk("wr_rdata", bus_if.m1_rdata, 0);
      chk("wr_err", bus_if.m1_err, 0);
      bus_if.m1_req = 0; bus_if.m1_we = 0; bus_if.bus_state = 2'b00;
      tick();

      // Contention: both held, expect m0, m1, m0, m1
      bus_if.m0_addr = 32'h100; bus_if.m1_addr = 32'h200;
      bus_if.m0_req = 1; bus_if.m1_req = 1;
      for (int i = 0; i < 4; i++) begin
         tick();                                         // cycle 1
         chk($sformatf("ct%0d_r_en", i), bus_if.bus_r_en, 1);
         chk($sformatf("ct%0d_addr", i), bus_if.bus_r_addr, (i % 2) ? 32'h200 : 32'h100);
         tick();                                         // cycle 2
         bus_if.bus_state = 2'b10; bus_if.bus_r_data = 32'h1000 + i;
         tick();                                         // cycle 3
         chk($sformatf("ct%0d_ack", i), {bus_if.m1_ack, bus_if.m0_ack},
             (i % 2) ? 32'h2 : 32'h1);
         chk($sformatf("ct%0d_rdata", i),
             (i % 2) ? bus_if.m1_rdata : bus_if.m0_rdata, 32'h1000 + i);
         bus_if.bus_state = 2'b00;
         tick();                                         // next IDLE
      end
      bus_if.m0_req = 0; bus_if.m1_req = 0;
      tick();

      // Timeout: bus stays idle, ack+err in cycle 7
      bus_if.m0_req = 1; bus_if.m0_addr = 32'hDEAD0000; bus_if.bus_r_data = 32'h12345678;
      for (int c = 1; c <= 6; c++) begin
         tick();
      end
      chk("to_ack_c6", bus_if.m0_ack, 0);
      tick();                                            // cycle 7
      chk("to_ack", bus_if.m0_ack, 1);
      chk("to_err", bus_if.m0_err, 1);
      chk("to_rdata", bus_if.m0_rdata, 0);
      bus_if.m0_req = 0;
      tick();                                            // cycle 8
      chk("to_ack_c8", {bus_if.m1_ack, bus_if.m0_ack}, 0);

      // Reset mid-WAIT, then contention grants m0 first
      bus_if.m0_req = 1; bus_if.m0_addr = 32'h300; bus_if.m1_addr = 32'h400;
      tick();                                            // cycle 1
      chk("mr_r_en", bus_if.bus_r_en, 1);
      tick();                                            // cycle 2
      rst = 1'b1;
      tick();                                            // cycle 3
      chk_all_zero("mr");
      rst = 1'b0; bus_if.m0_req = 0;
      bus_if.bus_state = 2'b10; bus_if.bus_r_data = 32'h55AA55AA;
      tick();                                            // cycle 4
      chk("mr_no_ack", {bus_if.m1_ack, bus_if.m0_ack, bus_if.bus_r_en}, 0);
      bus_if.bus_state = 2'b00;
      bus_if.m0_req = 1; bus_if.m1_req = 1;
      tick();
      chk("mr_first_addr", bus_if.bus_r_addr, 32'h300);
      tick();
      bus_if.bus_state = 2'b10; bus_if.bus_r_data = 32'h77;
      tick();
      chk("mr_first_ack", {bus_if.m1_ack, bus_if.m0_ack}, 2'b01);
      bus_if.bus_state = 2'b00; bus_if.m0_req = 0;
      tick();
      tick();
      chk("mr_second_addr", bus_if.bus_r_addr, 32'h400);
      tick();
      bus_if.bus_state = 2'b10; bus_if.bus_r_data = 32'h88;
      tick();
      chk("mr_second_ack", {bus_if.m1_ack, bus_if.m0_ack}, 2'b10);
      chk("mr_second_rdata", bus_if.m1_rdata, 32'h88);
      bus_if.bus_state = 2'b00; bus_if.m1_req = 0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-master arbiter and sequencer for the shared data bus, letting the core (master 0) and the debug/DMA engine (master 1) both reach data memory and peripherals. It sits between the masters and the bus decoders. Each transaction runs through a fixed issue/wait/respond sequence, gated by the bus `state` handshake and guarded by a timeout. Only one transaction is outstanding at a time; simultaneous requests alternate round-robin.

## Interface
- `TIMEOUT`, 255: max WAIT cycles before a transaction is aborted with error; 1..255
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `m0_req`, `m1_req`  in  1  request level, held until ack
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  32  byte address
- `m0_wdata`, `m1_wdata`  in  32  write data
- `m0_mode`, `m1_mode`  in  2  access size: 00 byte, 01 half, 10 word
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse
- `m0_err`, `m1_err`  out  1  timeout flag, valid with ack
- `m0_rdata`, `m1_rdata`  out  32  read data, valid with ack
- `bus_r_en`, `bus_w_en`  out  1  one-cycle bus strobes
- `bus_r_addr`, `bus_w_addr`  out  32  bus addresses
- `bus_r_mode`, `bus_w_mode`  out  2  bus access size
- `bus_w_data`  out  32  bus write data
- `bus_r_data`  in  32  muxed bus read data
- `bus_state`  in  2  00 idle, 01 busy, 10 done (1 cycle), 11 reserved (treated as busy)

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP. All outputs registered.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the master that was not granted last (`last` register).
  - On grant: latch we/addr/wdata/mode into internal registers, set `last` to the granted master, go to ISSUE.
- ISSUE (1 cycle):
  - Drive `bus_r_en` = !we or `bus_w_en` = we. Only one strobe is ever high.
  - Drive the latched addr/mode/wdata on the selected channel.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - If `bus_state` = 10: capture `bus_r_data` (zero it for writes), err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, take rdata=0, err=1, go to RESP.
  - Done takes precedence over timeout in the same cycle.
- RESP (1 cycle): pulse the granted master's ack with rdata/err, then go to IDLE.
- Non-granted master outputs stay 0 throughout.
- A master's req, we, addr, wdata and mode are sampled only in IDLE at grant. Changes after grant are ignored and the latched transaction always completes.
- Masters drop req on the edge that sees ack. A req still high in the IDLE cycle after ack is a new request.
- Bus addr/mode/wdata outputs hold their value until the next ISSUE; they are 0 after reset.

## Timing
- Reset (sync): state=IDLE, `last`=1 (master 0 wins the first contention), counter=0, every output = 0.
- Reset asserted mid-transaction aborts it: no ack, strobes drop on the next edge. The bus device may still complete; the arbiter ignores that completion.
- Latency from req high in IDLE (cycle 0):
  - ISSUE in cycle 1.
  - `bus_state`=10 in cycle k (k ≥ 2) gives ack in cycle k+1. Minimum 3 cycles.
  - Timeout: ack+err in cycle 3+TIMEOUT.
- Back-to-back: the next grant can be decided in the cycle after RESP. Throughput is at most one transaction per 4 cycles.
- `bus_state`=10 outside WAIT is ignored.

## Test plan
- **Single read:** m0 read at addr 0x1004, mode 10; bus gives state 01 in cycle 2, 10 with data 0xCAFEF00D in cycle 3.
  - Expect `bus_r_en` high only in cycle 1 with addr 0x1004.
  - Expect `m0_ack` in cycle 4 with rdata 0xCAFEF00D, err 0.
- **Write:** m1 write of 0x000000A5 to 0x10, mode 00.
  - Expect `bus_w_en` one cycle with addr 0x10 and data 0xA5; `bus_r_en` stays 0.
  - Expect `m1_ack` with rdata 0.
- **Contention:** both reqs held continuously after reset.
  - Expect grant order m0, m1, m0, m1, with the two acks alternating.
- **Timeout:** TIMEOUT=4, read to an unmapped address, `bus_state` held at 00.
  - Expect ack in cycle 7 with err=1, rdata=0; FSM returns to IDLE.
- **Reset mid-WAIT:** rst for 1 cycle in cycle 2 of a read.
  - Expect all outputs 0 on the next edge and no ack.
  - The following m1 and m0 contention grants m0 first.
